// File: rtl/jtag_bitbang_bridge.sv
`default_nettype none
// ============================================================================
// Module  : jtag_bitbang_bridge
// Brief   : Clocked FTDI bit-bang to multi-chain JTAG bridge with TCK regeneration.
// Rev     : 1.0
// ============================================================================
module jtag_bitbang_bridge #(
    parameter int NUM_CHAINS   = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 2,
    parameter int TCK_MIN_HALF = 4,
    parameter int IDLE_CYCLES  = 1024,
    parameter int CNT_W        = 16,
    localparam int CW          = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_host_tdi,
    input  logic                  i_host_tms,
    input  logic                  i_host_tck,
    output logic                  o_host_tdo,
    input  logic [CW-1:0]         i_chain_sel,
    output logic [NUM_CHAINS-1:0] o_jtag_tdi,
    output logic [NUM_CHAINS-1:0] o_jtag_tms,
    output logic [NUM_CHAINS-1:0] o_jtag_tck,
    input  logic [NUM_CHAINS-1:0] i_jtag_tdo,
    output logic                  o_active,
    output logic [CNT_W-1:0]      o_tck_count
);

    localparam int c_PH_W   = $clog2(TCK_MIN_HALF + 1);
    localparam int c_FLT_W  = $clog2(FILTER_LEN + 1);
    localparam int c_IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int c_PEND_W = 8;
    localparam logic [c_PEND_W-1:0] c_PEND_MAX = '1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(IDLE_CYCLES);
    localparam logic [c_PH_W-1:0]   c_PH_MIN   = c_PH_W'(TCK_MIN_HALF);
    localparam logic [c_FLT_W-1:0]  c_FLT_LAST = c_FLT_W'(FILTER_LEN - 1);

    typedef enum logic [0:0] {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_tdi_sync;
    logic [SYNC_STAGES-1:0] r_tms_sync;
    logic [SYNC_STAGES-1:0] r_tck_sync;
    logic [NUM_CHAINS-1:0]  r_tdo_sync [SYNC_STAGES];

    logic                   r_tck_f;
    logic [c_FLT_W-1:0]     r_flt_cnt;

    state_t                 r_state;
    logic [c_PH_W-1:0]      r_ph;
    logic [c_PEND_W-1:0]    r_pend;
    logic                   r_tdi;
    logic                   r_tms;
    logic [CW-1:0]          r_sel;
    logic [c_IDLE_W-1:0]    r_idle;
    logic                   r_active;
    logic [CNT_W-1:0]       r_tck_count;
    logic                   r_host_tdo;
    logic [NUM_CHAINS-1:0]  r_jtag_tck;
    logic [NUM_CHAINS-1:0]  r_jtag_tms;
    logic [NUM_CHAINS-1:0]  r_jtag_tdi;

    logic                   w_tdi_s;
    logic                   w_tms_s;
    logic                   w_tck_s;
    logic [NUM_CHAINS-1:0]  w_tdo_s;
    logic                   w_flt_upd;
    logic                   w_ph_ok;
    logic                   w_go;
    logic                   w_load;
    logic                   w_hi_nxt;
    logic                   w_tdi_nxt;
    logic                   w_tms_nxt;
    logic                   w_sel_upd;
    logic [CW-1:0]          w_sel_nxt;
    logic [c_IDLE_W-1:0]    w_idle_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdi_sync <= '0;
            r_tms_sync <= '1;
            r_tck_sync <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_tdo_sync[s] <= '0;
            end
        end else begin
            r_tdi_sync    <= {r_tdi_sync[SYNC_STAGES-2:0], i_host_tdi};
            r_tms_sync    <= {r_tms_sync[SYNC_STAGES-2:0], i_host_tms};
            r_tck_sync    <= {r_tck_sync[SYNC_STAGES-2:0], i_host_tck};
            r_tdo_sync[0] <= i_jtag_tdo;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_tdo_sync[s] <= r_tdo_sync[s-1];
            end
        end
    end

    assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];
    assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
    assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
    assign w_tdo_s = r_tdo_sync[SYNC_STAGES-1];

    // Filtered TCK follows the synced line only after FILTER_LEN consecutive differing cycles.
    assign w_flt_upd = (w_tck_s != r_tck_f) && (r_flt_cnt == c_FLT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tck_f   <= 1'b0;
            r_flt_cnt <= '0;
        end else if (w_tck_s == r_tck_f) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == c_FLT_LAST) begin
            r_tck_f   <= w_tck_s;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end

    // r_pend counts filtered edges not yet issued; issued and requested edges alternate from
    // the same reset level, so a non-zero count always requests the opposite of r_state.
    assign w_ph_ok   = (r_ph >= c_PH_MIN);
    assign w_go      = (r_pend != '0) && w_ph_ok;
    assign w_load    = (r_state == ST_LO) && !w_go;
    assign w_hi_nxt  = w_go ? (r_state == ST_LO) : (r_state == ST_HI);
    assign w_tdi_nxt = w_load ? w_tdi_s : r_tdi;
    assign w_tms_nxt = w_load ? w_tms_s : r_tms;

    assign w_sel_upd = (r_state == ST_LO) && !w_go && !r_active &&
                       ({1'b0, i_chain_sel} < (CW+1)'(NUM_CHAINS));
    assign w_sel_nxt = w_sel_upd ? i_chain_sel : r_sel;

    assign w_idle_nxt = w_go                      ? '0     :
                        (r_idle == c_IDLE_MAX)    ? r_idle :
                                                    r_idle + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LO;
            r_ph        <= '0;
            r_pend      <= '0;
            r_tdi       <= 1'b0;
            r_tms       <= 1'b1;
            r_sel       <= '0;
            r_idle      <= c_IDLE_MAX;
            r_active    <= 1'b0;
            r_tck_count <= '0;
            r_host_tdo  <= 1'b1;
            r_jtag_tck  <= '0;
            r_jtag_tms  <= '1;
            r_jtag_tdi  <= '0;
        end else begin
            if (w_go) begin
                r_state <= (r_state == ST_LO) ? ST_HI : ST_LO;
                r_ph    <= '0;
            end else if (!w_ph_ok) begin
                r_ph <= r_ph + 1'b1;
            end

            if (w_go && (r_state == ST_LO)) begin
                r_host_tdo  <= w_tdo_s[r_sel];
                r_tck_count <= r_tck_count + 1'b1;
            end

            // At saturation a further request drops a pair of edges to keep the parity.
            case ({w_flt_upd, w_go})
                2'b10:   r_pend <= (r_pend == c_PEND_MAX) ? c_PEND_MAX - 1'b1 : r_pend + 1'b1;
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase

            r_tdi    <= w_tdi_nxt;
            r_tms    <= w_tms_nxt;
            r_sel    <= w_sel_nxt;
            r_idle   <= w_idle_nxt;
            r_active <= (w_idle_nxt < c_IDLE_MAX);

            for (int i = 0; i < NUM_CHAINS; i++) begin
                if (CW'(i) == w_sel_nxt) begin
                    r_jtag_tck[i] <= w_hi_nxt;
                    r_jtag_tms[i] <= w_tms_nxt;
                    r_jtag_tdi[i] <= w_tdi_nxt;
                end else begin
                    r_jtag_tck[i] <= 1'b0;
                    r_jtag_tms[i] <= 1'b1;
                    r_jtag_tdi[i] <= 1'b0;
                end
            end
        end
    end

    assign o_host_tdo  = r_host_tdo;
    assign o_jtag_tck  = r_jtag_tck;
    assign o_jtag_tms  = r_jtag_tms;
    assign o_jtag_tdi  = r_jtag_tdi;
    assign o_active    = r_active;
    assign o_tck_count = r_tck_count;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bitbang_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtag_bitbang_bridge
// Brief   : Directed, table-driven self-checking bench for jtag_bitbang_bridge.
// Rev     : 1.0
// ============================================================================
module tb_jtag_bitbang_bridge;

    localparam int NC    = 3;
    localparam int CW    = 2;
    localparam int CNT_W = 4;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            host_tdi  = 1'b0;
    logic            host_tms  = 1'b1;
    logic            host_tck  = 1'b0;
    logic [CW-1:0]   chain_sel = '0;
    logic [NC-1:0]   jtag_tdo  = '1;
    wire             o_host_tdo;
    wire  [NC-1:0]   o_jtag_tdi;
    wire  [NC-1:0]   o_jtag_tms;
    wire  [NC-1:0]   o_jtag_tck;
    wire             o_active;
    wire  [CNT_W-1:0] o_tck_count;

    jtag_bitbang_bridge #(
        .NUM_CHAINS  (NC),
        .SYNC_STAGES (2),
        .FILTER_LEN  (2),
        .TCK_MIN_HALF(4),
        .IDLE_CYCLES (1024),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_host_tdi (host_tdi),
        .i_host_tms (host_tms),
        .i_host_tck (host_tck),
        .o_host_tdo (o_host_tdo),
        .i_chain_sel(chain_sel),
        .o_jtag_tdi (o_jtag_tdi),
        .o_jtag_tms (o_jtag_tms),
        .o_jtag_tck (o_jtag_tck),
        .i_jtag_tdo (jtag_tdo),
        .o_active   (o_active),
        .o_tck_count(o_tck_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    typedef struct {
        logic tms;
        logic tdi;
        logic tdo;
        logic exp_tms;
        logic exp_tdi;
        logic exp_tdo;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tck(input logic level, input int budget, output int lat);
        lat = 0;
        while (((|o_jtag_tck) != level) && (lat < budget)) begin
            @(negedge clk);
            lat++;
        end
        chk("tck_wait_bound", 32'(lat < budget), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_active && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(n < budget), 1);
    endtask

    task automatic pulse(input int hi, input int lo);
        host_tck = 1'b1;
        repeat (hi) @(negedge clk);
        host_tck = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        int   edges;
        int   run;
        int   min_run;
        logic prev;
        logic first;
        logic pre_tdi;
        logic pre_tms;

        vecs[0] = '{tms: 1'b1, tdi: 1'b0, tdo: 1'b0, exp_tms: 1'b1, exp_tdi: 1'b0, exp_tdo: 1'b0};
        vecs[1] = '{tms: 1'b0, tdi: 1'b1, tdo: 1'b1, exp_tms: 1'b0, exp_tdi: 1'b1, exp_tdo: 1'b1};
        vecs[2] = '{tms: 1'b1, tdi: 1'b1, tdo: 1'b0, exp_tms: 1'b1, exp_tdi: 1'b1, exp_tdo: 1'b0};
        vecs[3] = '{tms: 1'b0, tdi: 1'b0, tdo: 1'b1, exp_tms: 1'b0, exp_tdi: 1'b0, exp_tdo: 1'b1};

        // Reset held while every input toggles.
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            host_tdi  = i[0];
            host_tms  = i[1];
            host_tck  = i[0];
            jtag_tdo  = i[2:0];
            chain_sel = i[1:0];
        end
        @(negedge clk);
        chk("rst_tck",    32'(o_jtag_tck), 0);
        chk("rst_tms",    32'(o_jtag_tms), 32'h7);
        chk("rst_tdi",    32'(o_jtag_tdi), 0);
        chk("rst_tdo",    32'(o_host_tdo), 1);
        chk("rst_active", 32'(o_active), 0);
        chk("rst_count",  32'(o_tck_count), 0);

        host_tck  = 1'b0;
        host_tms  = 1'b1;
        host_tdi  = 1'b0;
        jtag_tdo  = '1;
        chain_sel = '0;
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_jtag_tck != '0) edges++;
        end
        chk("no_tck_after_reset", 32'(edges), 0);

        // First pulse: latency and data setup.
        host_tdi = 1'b1;
        host_tms = 1'b1;
        repeat (4) @(negedge clk);
        host_tck = 1'b1;
        lat = 0;
        pre_tdi = 1'b0;
        pre_tms = 1'b0;
        while ((o_jtag_tck == '0) && (lat < 20)) begin
            pre_tdi = o_jtag_tdi[0];
            pre_tms = o_jtag_tms[0];
            @(negedge clk);
            lat++;
        end
        exp_cnt++;
        chk("rise_latency",   32'(lat), 5);
        chk("setup_tdi",      32'(pre_tdi), 1);
        chk("setup_tms",      32'(pre_tms), 1);
        chk("rise_chain0",    32'(o_jtag_tck), 32'h1);
        chk("count_first",    32'(o_tck_count), 32'(exp_cnt));
        repeat (15) @(negedge clk);
        host_tck = 1'b0;
        wait_tck(1'b0, 20, lat);
        repeat (10) @(negedge clk);

        // One-cycle glitch must be dropped.
        host_tck = 1'b1;
        @(negedge clk);
        host_tck = 1'b0;
        edges = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (o_jtag_tck != '0) edges++;
        end
        chk("glitch_dropped", 32'(edges), 0);
        chk("glitch_count",   32'(o_tck_count), 32'(exp_cnt));

        // Host TCK toggling every 2 cycles: edges deferred, none lost.
        prev    = 1'b0;
        run     = 0;
        edges   = 0;
        min_run = 1000;
        first   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            host_tck = (i < 16) ? ~i[1] : 1'b0;
            @(negedge clk);
            if (o_jtag_tck[0] != prev) begin
                if (!first && (run < min_run)) min_run = run;
                first = 1'b0;
                run   = 1;
                edges++;
                prev  = o_jtag_tck[0];
            end else begin
                run++;
            end
        end
        exp_cnt += 4;
        chk("fast_edges",    32'(edges), 8);
        chk("fast_min_half", 32'(min_run >= 4), 1);
        chk("fast_count",    32'(o_tck_count), 32'(exp_cnt));
        chk("fast_end_low",  32'(o_jtag_tck), 0);

        // Table-driven TDI/TMS/TDO capture.
        for (int v = 0; v < 4; v++) begin
            host_tms    = vecs[v].tms;
            host_tdi    = vecs[v].tdi;
            jtag_tdo[0] = vecs[v].tdo;
            repeat (6) @(negedge clk);
            host_tck = 1'b1;
            wait_tck(1'b1, 20, lat);
            exp_cnt++;
            chk("vec_host_tdo", 32'(o_host_tdo),    32'(vecs[v].exp_tdo));
            chk("vec_tms",      32'(o_jtag_tms[0]), 32'(vecs[v].exp_tms));
            chk("vec_tdi",      32'(o_jtag_tdi[0]), 32'(vecs[v].exp_tdi));
            chk("vec_count",    32'(o_tck_count),   32'(exp_cnt));
            jtag_tdo[0] = ~vecs[v].tdo;
            repeat (4) @(negedge clk);
            chk("vec_tdo_held", 32'(o_host_tdo),    32'(vecs[v].exp_tdo));
            chk("vec_still_hi", 32'(o_jtag_tck[0]), 1);
            host_tck = 1'b0;
            wait_tck(1'b0, 20, lat);
            repeat (3) @(negedge clk);
        end

        // Chain switch is held off while active.
        host_tms  = 1'b1;
        chain_sel = 2'd1;
        chk("active_busy", 32'(o_active), 1);
        repeat (5) @(negedge clk);
        host_tck = 1'b1;
        wait_tck(1'b1, 20, lat);
        exp_cnt++;
        chk("busy_chain0", 32'(o_jtag_tck), 32'h1);
        repeat (6) @(negedge clk);
        host_tck = 1'b0;
        wait_tck(1'b0, 20, lat);

        wait_idle(1200);
        repeat (3) @(negedge clk);
        host_tck = 1'b1;
        wait_tck(1'b1, 20, lat);
        exp_cnt++;
        chk("switched_chain1", 32'(o_jtag_tck), 32'h2);
        chk("chain0_tms_idle", 32'(o_jtag_tms[0]), 1);
        chk("switch_count",    32'(o_tck_count), 32'(exp_cnt));
        repeat (6) @(negedge clk);
        host_tck = 1'b0;
        wait_tck(1'b0, 20, lat);

        chain_sel = 2'd3;
        wait_idle(1200);
        repeat (3) @(negedge clk);
        host_tck = 1'b1;
        wait_tck(1'b1, 20, lat);
        exp_cnt++;
        chk("sel3_ignored", 32'(o_jtag_tck), 32'h2);

        // Asynchronous reset during HI.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tck",   32'(o_jtag_tck), 0);
        chk("async_rst_count", 32'(o_tck_count), 0);
        chk("async_rst_tdo",   32'(o_host_tdo), 1);
        host_tck  = 1'b0;
        chain_sel = 2'd0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        repeat (5) @(negedge clk);

        // Counter wrap-around at 2^CNT_W.
        for (int p = 1; p <= 17; p++) begin
            pulse(8, 8);
            exp_cnt++;
            if (p >= 15) chk("wrap_count", 32'(o_tck_count), 32'(exp_cnt));
        end
        chk("wrap_final", 32'(o_tck_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
